// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multiport register file.
package regfile_pkg;

   localparam int unsigned XLEN_DEFAULT  = 64;
   localparam int unsigned NREGS_DEFAULT = 32;

   // Address width for a register count; a single register still needs one bit.
   function automatic int unsigned rf_asize(input int unsigned nregs);
      return (nregs < 2) ? 1 : $clog2(nregs);
   endfunction

   typedef logic [rf_asize(NREGS_DEFAULT)-1:0] rf_addr_t;
   typedef logic [XLEN_DEFAULT-1:0]            rf_data_t;

   localparam rf_data_t RF_RST_VAL = '0;

endpackage

// File: rtl/regfile_multiport_if.sv
// Request/response bundle between the issue stage (master) and the register file (slave).
interface regfile_multiport_if #(
   parameter int unsigned XLEN  = regfile_pkg::XLEN_DEFAULT,
   parameter int unsigned NREGS = regfile_pkg::NREGS_DEFAULT,
   parameter int unsigned NRD   = 2,
   parameter int unsigned NWR   = 1
) ();

   localparam int unsigned ASIZE = regfile_pkg::rf_asize(NREGS);

   logic [NRD-1:0]       rd_en;
   logic [NRD*ASIZE-1:0] rd_addr;
   logic [NRD*XLEN-1:0]  rd_data;
   logic [NRD-1:0]       rd_valid;
   logic [NRD-1:0]       rd_busy;
   logic [NWR-1:0]       wr_en;
   logic [NWR*ASIZE-1:0] wr_addr;
   logic [NWR*XLEN-1:0]  wr_data;
   logic                 rsv_en;
   logic [ASIZE-1:0]     rsv_addr;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd_data, rd_valid, rd_busy
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd_data, rd_valid, rd_busy
   );

endinterface

// File: rtl/regfile_wr_resolve.sv
// Matches one register address against all write ports; highest-index hitting port supplies the data.
module regfile_wr_resolve #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned NWR   = 1,
   parameter int unsigned ASIZE = 5
) (
   input  logic [ASIZE-1:0]     addr,
   input  logic [NWR-1:0]       wr_en,
   input  logic [NWR*ASIZE-1:0] wr_addr,
   input  logic [NWR*XLEN-1:0]  wr_data,
   output logic                 hit_c,
   output logic [XLEN-1:0]      data_c
);

   // Ascending scan so a later (higher) port overrides an earlier match.
   always_comb begin
      hit_c  = 1'b0;
      data_c = '0;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en[j] && (wr_addr[j*ASIZE +: ASIZE] == addr)) begin
            hit_c  = 1'b1;
            data_c = wr_data[j*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multiport register file with write-first read bypass and busy scoreboard.
// Optional REGFILE_TRACE_EN macro enables simulation-only write/WAW trace prints.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN    = XLEN_DEFAULT,
   parameter int unsigned NREGS   = NREGS_DEFAULT,
   parameter int unsigned NRD     = 2,
   parameter int unsigned NWR     = 1,
   parameter bit          ZERO_R0 = 1'b0
) (
   input logic                clk,
   input logic                rst,
   regfile_multiport_if.slave bus
);

   localparam int unsigned ASIZE = rf_asize(NREGS);
   localparam logic [NREGS-1:0] LOCK_MASK = ZERO_R0 ? NREGS'(1) : '0;

   logic [XLEN-1:0]     regs [NREGS];
   logic [NREGS-1:0]    busy;
   logic [NREGS-1:0]    busy_nxt;
   logic [NREGS-1:0]    arr_hit_c;
   logic [XLEN-1:0]     arr_data_c [NREGS];
   logic [NREGS-1:0]    wr_mask;
   logic [NREGS-1:0]    rsv_mask;

   logic [ASIZE-1:0]    rd_addr_a [NRD];
   logic [NRD-1:0]      rd_hit_c;
   logic [XLEN-1:0]     rd_wdata_c [NRD];
   logic [XLEN-1:0]     rd_data_nxt [NRD];
   logic [NRD-1:0]      rd_busy_nxt;

   logic [NRD*XLEN-1:0] rd_data_q;
   logic [NRD-1:0]      rd_valid_q;
   logic [NRD-1:0]      rd_busy_q;

   // Per-register write conflict resolution.
   for (genvar r = 0; r < NREGS; r++) begin : g_arr
      regfile_wr_resolve #(.XLEN(XLEN), .NWR(NWR), .ASIZE(ASIZE)) u_arr_resolve (
         .addr    (ASIZE'(r)),
         .wr_en   (bus.wr_en),
         .wr_addr (bus.wr_addr),
         .wr_data (bus.wr_data),
         .hit_c   (arr_hit_c[r]),
         .data_c  (arr_data_c[r])
      );
   end

   // Per-read-port bypass lookup.
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      assign rd_addr_a[i] = bus.rd_addr[i*ASIZE +: ASIZE];

      regfile_wr_resolve #(.XLEN(XLEN), .NWR(NWR), .ASIZE(ASIZE)) u_rd_resolve (
         .addr    (rd_addr_a[i]),
         .wr_en   (bus.wr_en),
         .wr_addr (bus.wr_addr),
         .wr_data (bus.wr_data),
         .hit_c   (rd_hit_c[i]),
         .data_c  (rd_wdata_c[i])
      );
   end

   // Scoreboard next state: writes clear, reserve sets and wins over a same-cycle write.
   always_comb begin
      wr_mask  = arr_hit_c & ~LOCK_MASK;
      rsv_mask = '0;
      if (bus.rsv_en) begin
         rsv_mask = (NREGS'(1) << bus.rsv_addr) & ~LOCK_MASK;
      end
      busy_nxt = (busy & ~wr_mask) | rsv_mask;
   end

   // Read values as seen after this edge's writes and scoreboard updates.
   always_comb begin
      rd_busy_nxt = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_data_nxt[i] = rd_hit_c[i] ? rd_wdata_c[i] : regs[rd_addr_a[i]];
         rd_busy_nxt[i] = busy_nxt[rd_addr_a[i]];
         if (ZERO_R0 && (rd_addr_a[i] == '0)) begin
            rd_data_nxt[i] = '0;
            rd_busy_nxt[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= XLEN'(RF_RST_VAL);
         end
         busy <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (wr_mask[r]) begin
               regs[r] <= arr_data_c[r];
            end
         end
         busy <= busy_nxt;
      end
   end

   // Read port registers; data and busy hold while the port is idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= '0;
         rd_busy_q  <= '0;
      end else begin
         rd_valid_q <= bus.rd_en;
         for (int i = 0; i < NRD; i++) begin
            if (bus.rd_en[i]) begin
               rd_data_q[i*XLEN +: XLEN] <= rd_data_nxt[i];
               rd_busy_q[i]              <= rd_busy_nxt[i];
            end
         end
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_busy  = rd_busy_q;

`ifdef REGFILE_TRACE_EN
   // Trace accepted writes; dump the file when a reserve lands on a busy register.
   always @(posedge clk) begin
      if (!rst) begin
         for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] &&
                !(ZERO_R0 && (bus.wr_addr[j*ASIZE +: ASIZE] == '0))) begin
               $display("%0t regfile wr port=%0d addr=%0d data=%h", $time, j,
                        bus.wr_addr[j*ASIZE +: ASIZE], bus.wr_data[j*XLEN +: XLEN]);
            end
         end
         if ((rsv_mask & busy) != '0) begin
            $display("%0t regfile WAW warning: reserve of busy r%0d", $time, bus.rsv_addr);
            for (int r = 0; r < NREGS; r++) begin
               $display("  r%0d = %h busy=%b", r, regs[r], busy[r]);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench: two register files (ZERO_R0 off/on) driven with identical stimulus.
module tb_regfile_multiport;
   import regfile_pkg::*;

   localparam int unsigned XL = 64;
   localparam int unsigned NR = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0] rd_en;
   rf_addr_t   rd_addr [2];
   logic [1:0] wr_en;
   rf_addr_t   wr_addr [2];
   rf_data_t   wr_data [2];
   logic       rsv_en;
   rf_addr_t   rsv_addr;

   regfile_multiport_if #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2)) bus0 ();
   regfile_multiport_if #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2)) bus1 ();

   assign bus0.rd_en    = rd_en;
   assign bus0.rd_addr  = {rd_addr[1], rd_addr[0]};
   assign bus0.wr_en    = wr_en;
   assign bus0.wr_addr  = {wr_addr[1], wr_addr[0]};
   assign bus0.wr_data  = {wr_data[1], wr_data[0]};
   assign bus0.rsv_en   = rsv_en;
   assign bus0.rsv_addr = rsv_addr;
   assign bus1.rd_en    = rd_en;
   assign bus1.rd_addr  = {rd_addr[1], rd_addr[0]};
   assign bus1.wr_en    = wr_en;
   assign bus1.wr_addr  = {wr_addr[1], wr_addr[0]};
   assign bus1.wr_data  = {wr_data[1], wr_data[0]};
   assign bus1.rsv_en   = rsv_en;
   assign bus1.rsv_addr = rsv_addr;

   regfile_multiport #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2), .ZERO_R0(1'b0)) dut0 (
      .clk (clk), .rst (rst), .bus (bus0));
   regfile_multiport #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2), .ZERO_R0(1'b1)) dut1 (
      .clk (clk), .rst (rst), .bus (bus1));

   int total = 0;
   int bad   = 0;

   // Reference model: k=0 plain file, k=1 with hardwired zero register.
   rf_data_t m_reg  [2][NR];
   bit       m_busy [2][NR];
   rf_data_t exp_data  [2][2];
   bit       exp_valid [2][2];
   bit       exp_busy  [2][2];

   function automatic rf_data_t dut_data(input int k, input int i);
      logic [2*XL-1:0] v;
      v = (k == 0) ? bus0.rd_data : bus1.rd_data;
      return v[i*XL +: XL];
   endfunction

   function automatic logic dut_valid(input int k, input int i);
      logic [1:0] v;
      v = (k == 0) ? bus0.rd_valid : bus1.rd_valid;
      return v[i];
   endfunction

   function automatic logic dut_busy(input int k, input int i);
      logic [1:0] v;
      v = (k == 0) ? bus0.rd_busy : bus1.rd_busy;
      return v[i];
   endfunction

   task automatic idle();
      rd_en = '0; wr_en = '0; rsv_en = 1'b0; rsv_addr = '0;
      for (int p = 0; p < 2; p++) begin
         rd_addr[p] = '0; wr_addr[p] = '0; wr_data[p] = '0;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < NR; r++) begin
            m_reg[k][r] = '0; m_busy[k][r] = 1'b0;
         end
         for (int i = 0; i < 2; i++) begin
            exp_data[k][i] = '0; exp_valid[k][i] = 1'b0; exp_busy[k][i] = 1'b0;
         end
      end
   endtask

   // Apply the current stimulus to the model, then advance one clock and settle.
   task automatic step();
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 2; j++) begin
            if (wr_en[j] && !(k == 1 && wr_addr[j] == 0)) begin
               m_reg[k][wr_addr[j]]  = wr_data[j];
               m_busy[k][wr_addr[j]] = 1'b0;
            end
         end
         if (rsv_en && !(k == 1 && rsv_addr == 0)) m_busy[k][rsv_addr] = 1'b1;
         for (int i = 0; i < 2; i++) begin
            exp_valid[k][i] = rd_en[i];
            if (rd_en[i]) begin
               exp_data[k][i] = m_reg[k][rd_addr[i]];
               exp_busy[k][i] = m_busy[k][rd_addr[i]];
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      model_reset();
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 2; i++) begin
            total++;
            if (dut_data(k, i) !== '0 || dut_valid(k, i) !== 1'b0 || dut_busy(k, i) !== 1'b0) begin
               bad++;
               $display("FAIL reset_state k=%0d port=%0d got data=%h valid=%b busy=%b want 0/0/0",
                        k, i, dut_data(k, i), dut_valid(k, i), dut_busy(k, i));
            end
         end
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_bypass();
      idle();
      wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 64'h11;
      step();
      wr_data[0] = 64'hAA;
      rd_en = 2'b10; rd_addr[1] = 5'd3;
      step();
      for (int k = 0; k < 2; k++) begin
         total++;
         if (dut_data(k, 1) !== 64'hAA || dut_valid(k, 1) !== 1'b1 || dut_valid(k, 0) !== 1'b0) begin
            bad++;
            $display("FAIL bypass k=%0d got data1=%h valid=%b%b want data1=aa valid=10",
                     k, dut_data(k, 1), dut_valid(k, 1), dut_valid(k, 0));
         end
      end
      idle();
   endtask

   task automatic test_write_conflict();
      idle();
      wr_en = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
      wr_data[0] = 64'h1; wr_data[1] = 64'h2;
      rd_en = 2'b10; rd_addr[1] = 5'd7;
      step();
      idle();
      rd_en = 2'b01; rd_addr[0] = 5'd7;
      step();
      for (int k = 0; k < 2; k++) begin
         total++;
         if (dut_data(k, 1) !== 64'h2 || dut_data(k, 0) !== 64'h2) begin
            bad++;
            $display("FAIL write_conflict k=%0d got bypass=%h stored=%h want 2/2",
                     k, dut_data(k, 1), dut_data(k, 0));
         end
      end
      idle();
   endtask

   task automatic test_scoreboard();
      logic [63:0] want_d [4];
      logic        want_b [4];
      want_d = '{64'h2, 64'h55, 64'h66, 64'h66};
      want_b = '{1'b1, 1'b0, 1'b1, 1'b0};
      // Set up r9 with known data first.
      idle();
      wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 64'h2;
      step();
      for (int ph = 0; ph < 4; ph++) begin
         idle();
         case (ph)
            0: begin rsv_en = 1'b1; rsv_addr = 5'd9; end
            1: begin wr_en = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 64'h55; end
            2: begin rsv_en = 1'b1; rsv_addr = 5'd9;
                     wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 64'h66; end
            default: begin wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 64'h66; end
         endcase
         // Second reserve on an already busy register must not need two clears.
         if (ph == 2) begin
            step();
            idle();
            rsv_en = 1'b1; rsv_addr = 5'd9;
         end
         step();
         idle();
         rd_en = 2'b01; rd_addr[0] = 5'd9;
         step();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (dut_data(k, 0) !== want_d[ph] || dut_busy(k, 0) !== want_b[ph]) begin
               bad++;
               $display("FAIL scoreboard ph=%0d k=%0d got data=%h busy=%b want data=%h busy=%b",
                        ph, k, dut_data(k, 0), dut_busy(k, 0), want_d[ph], want_b[ph]);
            end
         end
      end
      idle();
   endtask

   task automatic test_zero_r0();
      idle();
      wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 64'hFF;
      rsv_en = 1'b1; rsv_addr = 5'd0;
      step();
      idle();
      rd_en = 2'b11; rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
      step();
      for (int i = 0; i < 2; i++) begin
         total++;
         if (dut_data(0, i) !== 64'hFF || dut_busy(0, i) !== 1'b1) begin
            bad++;
            $display("FAIL r0_plain port=%0d got data=%h busy=%b want ff/1", i, dut_data(0, i), dut_busy(0, i));
         end
         total++;
         if (dut_data(1, i) !== 64'h0 || dut_busy(1, i) !== 1'b0) begin
            bad++;
            $display("FAIL r0_zero port=%0d got data=%h busy=%b want 0/0", i, dut_data(1, i), dut_busy(1, i));
         end
      end
      idle();
   endtask

   task automatic test_hold();
      idle();
      wr_en = 2'b01; wr_addr[0] = 5'd12; wr_data[0] = 64'hC0FFEE;
      rd_en = 2'b01; rd_addr[0] = 5'd12;
      step();
      for (int c = 0; c < 3; c++) begin
         idle();
         rd_addr[0] = 5'd12;
         wr_en = 2'b10; wr_addr[1] = 5'd12; wr_data[1] = 64'(c + 100);
         rsv_en = 1'b1; rsv_addr = 5'd12;
         step();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (dut_data(k, 0) !== 64'hC0FFEE || dut_valid(k, 0) !== 1'b0 || dut_busy(k, 0) !== 1'b0) begin
               bad++;
               $display("FAIL hold c=%0d k=%0d got data=%h valid=%b busy=%b want c0ffee/0/0",
                        c, k, dut_data(k, 0), dut_valid(k, 0), dut_busy(k, 0));
            end
         end
      end
      idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         int unsigned hi;
         hi = (c % 4 == 0) ? 31 : 7;
         rd_en  = 2'($urandom_range(0, 3));
         wr_en  = 2'($urandom_range(0, 3));
         rsv_en = 1'($urandom_range(0, 1));
         rsv_addr = rf_addr_t'($urandom_range(0, hi));
         for (int p = 0; p < 2; p++) begin
            rd_addr[p] = rf_addr_t'($urandom_range(0, hi));
            wr_addr[p] = rf_addr_t'($urandom_range(0, hi));
            wr_data[p] = {32'($urandom), 32'($urandom)};
         end
         step();
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
               total++;
               if (dut_data(k, i) !== exp_data[k][i] || dut_valid(k, i) !== exp_valid[k][i] ||
                   dut_busy(k, i) !== exp_busy[k][i]) begin
                  bad++;
                  $display("FAIL random c=%0d k=%0d port=%0d got %h/%b/%b want %h/%b/%b", c, k, i,
                           dut_data(k, i), dut_valid(k, i), dut_busy(k, i),
                           exp_data[k][i], exp_valid[k][i], exp_busy[k][i]);
               end
            end
         end
      end
      idle();
   endtask

   task automatic test_reset_midrun();
      idle();
      wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 64'h1234;
      rsv_en = 1'b1; rsv_addr = 5'd5;
      step();
      idle();
      rd_en = 2'b11; rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
      step();
      total++;
      if (dut_data(0, 0) !== 64'h1234 || dut_busy(0, 0) !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset got data=%h busy=%b want 1234/1", dut_data(0, 0), dut_busy(0, 0));
      end
      #3;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 2; i++) begin
            total++;
            if (dut_data(k, i) !== '0 || dut_valid(k, i) !== 1'b0 || dut_busy(k, i) !== 1'b0) begin
               bad++;
               $display("FAIL async_reset k=%0d port=%0d got %h/%b/%b want 0/0/0",
                        k, i, dut_data(k, i), dut_valid(k, i), dut_busy(k, i));
            end
         end
      end
      // Traffic while reset is held is discarded.
      wr_en = 2'b11; wr_addr[0] = 5'd5; wr_addr[1] = 5'd5;
      wr_data[0] = 64'h99; wr_data[1] = 64'h98;
      rsv_en = 1'b1; rsv_addr = 5'd5;
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
      idle();
      rd_en = 2'b01; rd_addr[0] = 5'd5;
      step();
      for (int k = 0; k < 2; k++) begin
         total++;
         if (dut_data(k, 0) !== 64'h0 || dut_busy(k, 0) !== 1'b0 || dut_valid(k, 0) !== 1'b1) begin
            bad++;
            $display("FAIL post_reset k=%0d got %h/%b/%b want 0/1/0",
                     k, dut_data(k, 0), dut_valid(k, 0), dut_busy(k, 0));
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_write_conflict();
      test_scoreboard();
      test_zero_r0();
      test_hold();
      test_random();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
